// File: rtl/spi_adc_sampler.sv
// SPI master for an ADC128S022-style converter: round-robin channel scan into a one-deep
// valid/ready sample register. Define SPI_ADC_OVERRUN_CNT_EN to add the overrun_count port.
module spi_adc_sampler #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int FRAME_BITS   = 16,
   parameter int CLK_DIV      = 4,
   parameter int CS_IDLE      = 2,
   parameter int CHANNELS     = 1,
   localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                    clock,
   input  logic                    nreset,
   input  logic                    enable,
   output logic                    spi_clock,
   output logic                    spi_chipselect,
   output logic                    spi_mosi,
   input  logic                    spi_data,
   output logic [SAMPLE_WIDTH-1:0] sample_data,
   output logic [CH_W-1:0]         sample_channel,
   output logic                    sample_valid,
   input  logic                    sample_ready,
   output logic                    overrun
`ifdef SPI_ADC_OVERRUN_CNT_EN
   ,
   output logic [15:0]             overrun_count
`endif
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int CNT_W = $clog2(2 * FRAME_BITS + CS_IDLE + 1);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

   state_t                state, state_next;
   logic [DIV_W-1:0]      div, div_next;
   logic [CNT_W-1:0]      cnt, cnt_next;
   logic [FRAME_BITS-1:0] shreg, shreg_next;
   logic [CH_W-1:0]       pend_ch, pend_ch_next, addr_ch;
   logic [2:0]            addr;
   logic                  sclk_next, mosi_next, done, done_next, tick;

   assign tick           = (div == DIV_W'(CLK_DIV - 1));
   assign addr_ch        = (pend_ch == CH_W'(CHANNELS - 1)) ? '0 : pend_ch + CH_W'(1);
   assign addr           = 3'(addr_ch);
   assign spi_chipselect = (state == IDLE) || (state == GAP);
   assign overrun        = done && sample_valid && !sample_ready;

   // SHIFT counts half-periods: even ticks raise the clock and sample MISO, odd ticks
   // lower it and present the next address bit; the last half-period stays high.
   always_comb begin
      state_next   = state;
      div_next     = div;
      cnt_next     = cnt;
      shreg_next   = shreg;
      pend_ch_next = pend_ch;
      sclk_next    = spi_clock;
      mosi_next    = spi_mosi;
      done_next    = 1'b0;
      if (state != IDLE) div_next = tick ? '0 : div + DIV_W'(1);
      case (state)
         IDLE: begin
            div_next = '0;
            if (enable) begin
               state_next   = SETUP;
               pend_ch_next = '0;
            end
         end
         SETUP: begin
            if (tick) begin
               state_next = SHIFT;
               cnt_next   = '0;
               sclk_next  = 1'b0;
               mosi_next  = 1'b0;
            end
         end
         SHIFT: begin
            if (tick) begin
               cnt_next = cnt + CNT_W'(1);
               if (cnt == CNT_W'(2 * FRAME_BITS - 1)) begin
                  state_next   = GAP;
                  cnt_next     = '0;
                  pend_ch_next = addr_ch;
               end else if (!cnt[0]) begin
                  sclk_next  = 1'b1;
                  shreg_next = {shreg[FRAME_BITS-2:0], spi_data};
                  done_next  = (cnt == CNT_W'(2 * FRAME_BITS - 2));
               end else begin
                  sclk_next = 1'b0;
                  if (cnt == CNT_W'(3))      mosi_next = addr[2];
                  else if (cnt == CNT_W'(5)) mosi_next = addr[1];
                  else if (cnt == CNT_W'(7)) mosi_next = addr[0];
                  else                       mosi_next = 1'b0;
               end
            end
         end
         GAP: begin
            if (tick) begin
               cnt_next = cnt + CNT_W'(1);
               if (cnt == CNT_W'(CS_IDLE - 1)) begin
                  cnt_next   = '0;
                  state_next = enable ? SETUP : IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state     <= IDLE;
         div       <= '0;
         cnt       <= '0;
         shreg     <= '0;
         pend_ch   <= '0;
         spi_clock <= 1'b1;
         spi_mosi  <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_next;
         div       <= div_next;
         cnt       <= cnt_next;
         shreg     <= shreg_next;
         pend_ch   <= pend_ch_next;
         spi_clock <= sclk_next;
         spi_mosi  <= mosi_next;
         done      <= done_next;
      end
   end

   // A completed sample replaces the held one only if the register is empty or being drained.
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         sample_data    <= '0;
         sample_channel <= '0;
         sample_valid   <= 1'b0;
      end else if (done && (!sample_valid || sample_ready)) begin
         sample_data    <= shreg[SAMPLE_WIDTH-1:0];
         sample_channel <= pend_ch;
         sample_valid   <= 1'b1;
      end else if (sample_valid && sample_ready) begin
         sample_valid <= 1'b0;
      end
   end

`ifdef SPI_ADC_OVERRUN_CNT_EN
   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset)                                  overrun_count <= '0;
      else if (overrun && overrun_count != 16'hFFFF) overrun_count <= overrun_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_spi_adc_sampler.sv
// Directed bench for spi_adc_sampler with a 4-channel scan, CLK_DIV=2, CS_IDLE=2.
// An ADC model shifts a per-frame word out on falling spi_clock edges.
module tb_spi_adc_sampler;

   logic        clock = 1'b0, nreset = 1'b0, enable = 1'b0, spi_data = 1'b0, sample_ready = 1'b0;
   logic        spi_clock, spi_chipselect, spi_mosi, sample_valid, overrun;
   logic [15:0] sample_data;
   logic [1:0]  sample_channel;
`ifdef SPI_ADC_OVERRUN_CNT_EN
   logic [15:0] overrun_count;
`endif

   int checks = 0, errors = 0;

   logic [15:0] word_tbl [8] = '{16'hA5C3, 16'h1234, 16'hBEEF, 16'h0F0F,
                                 16'h8001, 16'h7FFE, 16'hC0DE, 16'h5A5A};

   always #5 clock = ~clock;

   spi_adc_sampler #(
      .SAMPLE_WIDTH(16), .FRAME_BITS(16), .CLK_DIV(2), .CS_IDLE(2), .CHANNELS(4)
   ) dut (
      .clock(clock), .nreset(nreset), .enable(enable),
      .spi_clock(spi_clock), .spi_chipselect(spi_chipselect), .spi_mosi(spi_mosi),
      .spi_data(spi_data), .sample_data(sample_data), .sample_channel(sample_channel),
      .sample_valid(sample_valid), .sample_ready(sample_ready), .overrun(overrun)
`ifdef SPI_ADC_OVERRUN_CNT_EN
      , .overrun_count(overrun_count)
`endif
   );

   // ADC model: a chip-select fall picks the frame's word, each falling clock presents the next bit.
   logic [15:0] cur_word = '0;
   int          adc_frame = 0, bit_idx = 0;
   always @(negedge spi_clock or negedge spi_chipselect) begin
      if (spi_clock) begin
         cur_word  = word_tbl[adc_frame % 8];
         adc_frame = adc_frame + 1;
         bit_idx   = 0;
      end else if (!spi_chipselect && bit_idx < 16) begin
         spi_data = cur_word[15 - bit_idx];
         bit_idx  = bit_idx + 1;
      end
   end

   int cyc = 0;
   always @(posedge clock) cyc = cyc + 1;

   logic       cs_q = 1'b1, sclk_q = 1'b1, valid_q = 1'b0, fall_seen = 1'b0;
   logic [2:0] addr_bits = '0;
   int         frames_started = 0, frames_done = 0, rise_in_frame = 0, last_frame_rises = 0;
   int         last_rise_cyc = 0, first_fall_cyc = 0, valid_rise_cyc = 0;
   int         ovr_pulses = 0, ovr_len = 0, ovr_max = 0;
   int         csfall_q[$], addr_q[$], acc_data[$], acc_ch[$];

   // Bus monitor sampled mid-cycle: frame timing, MOSI address, handshakes and overrun pulses.
   always @(negedge clock) begin
      if (!spi_chipselect && cs_q) begin
         frames_started = frames_started + 1;
         csfall_q.push_back(cyc);
         rise_in_frame = 0;
         fall_seen     = 1'b0;
      end
      if (spi_chipselect && !cs_q) begin
         frames_done      = frames_done + 1;
         last_frame_rises = rise_in_frame;
      end
      if (!spi_chipselect && !spi_clock && sclk_q && !fall_seen) begin
         fall_seen      = 1'b1;
         first_fall_cyc = cyc;
      end
      if (!spi_chipselect && spi_clock && !sclk_q) begin
         case (rise_in_frame)
            2:       addr_bits[2] = spi_mosi;
            3:       addr_bits[1] = spi_mosi;
            4:       addr_bits[0] = spi_mosi;
            default: ;
         endcase
         rise_in_frame = rise_in_frame + 1;
         last_rise_cyc = cyc;
         if (rise_in_frame == 5) addr_q.push_back(int'(addr_bits));
      end
      if (sample_valid && !valid_q) valid_rise_cyc = cyc;
      if (sample_valid && sample_ready) begin
         acc_data.push_back(int'(sample_data));
         acc_ch.push_back(int'(sample_channel));
      end
      if (overrun) begin
         ovr_len = ovr_len + 1;
         if (ovr_len == 1) ovr_pulses = ovr_pulses + 1;
         if (ovr_len > ovr_max) ovr_max = ovr_len;
      end else begin
         ovr_len = 0;
      end
      cs_q    = spi_chipselect;
      sclk_q  = spi_clock;
      valid_q = sample_valid;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic rdy);
      @(posedge clock);
      #1;
      enable       = en;
      sample_ready = rdy;
   endtask

   task automatic applyReset();
      @(posedge clock);
      #1;
      nreset       = 1'b0;
      enable       = 1'b0;
      sample_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      nreset = 1'b1;
   endtask

   // Returns 1 ns after the clock edge on which the target-th rising spi_clock appears.
   task automatic waitRises(input int target, output int seen);
      logic prev;
      seen = 0;
      prev = spi_clock;
      for (int i = 0; i < 3000 && seen < target; i++) begin
         @(posedge clock);
         #1;
         if (spi_clock && !prev && !spi_chipselect) seen = seen + 1;
         prev = spi_clock;
      end
   endtask

   initial begin
      int base, acc0, cf0, addr0, done0, ovr0, seen;

      $display("[TB] reset state");
      repeat (3) @(posedge clock);
      @(negedge clock);
      checkOutput("rst_cs", spi_chipselect, 1);
      checkOutput("rst_sclk", spi_clock, 1);
      checkOutput("rst_mosi", spi_mosi, 0);
      checkOutput("rst_valid", sample_valid, 0);
      checkOutput("rst_data", sample_data, 0);
      checkOutput("rst_chan", sample_channel, 0);
      checkOutput("rst_ovr", overrun, 0);
`ifdef SPI_ADC_OVERRUN_CNT_EN
      checkOutput("rst_ovr_cnt", overrun_count, 0);
`endif

      $display("[TB] first frame timing and channel scan");
      @(posedge clock);
      #1;
      nreset = 1'b1;
      base  = frames_started;
      acc0  = acc_data.size();
      cf0   = csfall_q.size();
      addr0 = addr_q.size();
      applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 400 && acc_data.size() == acc0; i++) @(negedge clock);
      checkOutput("t1_first_sample", acc_data.size() > acc0, 1);
      checkOutput("t1_cs_to_fall", first_fall_cyc - csfall_q[cf0], 2);
      checkOutput("t1_rise_to_valid", valid_rise_cyc - last_rise_cyc, 1);
      for (int i = 0; i < 1200 && (acc_data.size() < acc0 + 6 || addr_q.size() < addr0 + 6); i++)
         @(negedge clock);
      checkOutput("t2_six_samples", (acc_data.size() >= acc0 + 6) && (addr_q.size() >= addr0 + 6), 1);
      if (acc_data.size() >= acc0 + 6 && addr_q.size() >= addr0 + 6) begin
         checkOutput("t1_frame_period", csfall_q[cf0 + 1] - csfall_q[cf0], 70);
         checkOutput("t1_rises", last_frame_rises, 16);
         for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("t2_data%0d", k), acc_data[acc0 + k], word_tbl[(base + k) % 8]);
            checkOutput($sformatf("t2_chan%0d", k), acc_ch[acc0 + k], k % 4);
            checkOutput($sformatf("t2_addr%0d", k), addr_q[addr0 + k], (k + 1) % 4);
         end
      end

      $display("[TB] backpressure across three frames");
      applyReset();
      base  = frames_started;
      done0 = frames_done;
      ovr0  = ovr_pulses;
      applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < 500 && frames_done < done0 + 3; i++) @(negedge clock);
      checkOutput("t3_three_frames", frames_done >= done0 + 3, 1);
      applyStimulus(1'b0, 1'b0);
      @(negedge clock);
      checkOutput("t3_valid_held", sample_valid, 1);
      checkOutput("t3_data_held", sample_data, word_tbl[base % 8]);
      checkOutput("t3_chan_held", sample_channel, 0);
      checkOutput("t3_ovr_pulses", ovr_pulses - ovr0, 2);
      checkOutput("t3_ovr_width", ovr_max, 1);
`ifdef SPI_ADC_OVERRUN_CNT_EN
      checkOutput("t3_ovr_count", overrun_count, 2);
`endif
      repeat (10) @(posedge clock);
      applyStimulus(1'b0, 1'b1);
      @(negedge clock);
      checkOutput("t3_valid_before_drain", sample_valid, 1);
      @(negedge clock);
      checkOutput("t3_valid_drained", sample_valid, 0);
      applyStimulus(1'b0, 1'b0);

      $display("[TB] ready on the completion cycle");
      repeat (5) @(posedge clock);
      base = frames_started;
      ovr0 = ovr_pulses;
      applyStimulus(1'b1, 1'b0);
      waitRises(32, seen);
      checkOutput("t4_rises", seen, 32);
      sample_ready = 1'b1;
      enable       = 1'b0;
      @(posedge clock);
      #1;
      sample_ready = 1'b0;
      @(negedge clock);
      checkOutput("t4_valid", sample_valid, 1);
      checkOutput("t4_data", sample_data, word_tbl[(base + 1) % 8]);
      checkOutput("t4_chan", sample_channel, 1);
      checkOutput("t4_no_ovr", ovr_pulses - ovr0, 0);
`ifdef SPI_ADC_OVERRUN_CNT_EN
      checkOutput("t4_ovr_count", overrun_count, 2);
`endif
      applyStimulus(1'b0, 1'b1);
      repeat (3) @(posedge clock);

      $display("[TB] enable dropped mid-frame");
      applyReset();
      base = frames_started;
      acc0 = acc_data.size();
      applyStimulus(1'b1, 1'b1);
      waitRises(8, seen);
      checkOutput("t5_rises", seen, 8);
      enable = 1'b0;
      for (int i = 0; i < 300 && acc_data.size() == acc0; i++) @(negedge clock);
      checkOutput("t5_delivered", acc_data.size() > acc0, 1);
      if (acc_data.size() > acc0) begin
         checkOutput("t5_data", acc_data[acc0], word_tbl[base % 8]);
         checkOutput("t5_chan", acc_ch[acc0], 0);
      end
      repeat (60) @(negedge clock);
      checkOutput("t5_cs_idle", spi_chipselect, 1);
      checkOutput("t5_sclk_idle", spi_clock, 1);
      checkOutput("t5_one_frame", frames_started - base, 1);
      checkOutput("t5_frame_rises", last_frame_rises, 16);

      $display("[TB] asynchronous reset mid-frame");
      applyReset();
      base = frames_started;
      applyStimulus(1'b1, 1'b0);
      waitRises(21, seen);
      checkOutput("t6_rises", seen, 21);
      #2;
      nreset = 1'b0;
      #1;
      checkOutput("t6_cs", spi_chipselect, 1);
      checkOutput("t6_sclk", spi_clock, 1);
      checkOutput("t6_valid", sample_valid, 0);
      @(posedge clock);
      #1;
      nreset = 1'b1;
      acc0 = acc_data.size();
      applyStimulus(1'b1, 1'b1);
      for (int i = 0; i < 300 && acc_data.size() == acc0; i++) @(negedge clock);
      checkOutput("t6_sample", acc_data.size() > acc0, 1);
      if (acc_data.size() > acc0) begin
         checkOutput("t6_chan", acc_ch[acc0], 0);
         checkOutput("t6_data", acc_data[acc0], word_tbl[(base + 2) % 8]);
      end
      applyStimulus(1'b0, 1'b1);
      repeat (80) @(posedge clock);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
